bin_win3x3_gen: RTL and testbench
=================================

# bin_win3x3_gen

Generates a 3×3 binary neighbourhood window from a raster-ordered 1-bit pixel stream for the morphology stages (erode/dilate) that follow it in the HDMI picture pipeline. It sits between the binarisation stage and the erode/dilate cores. It buffers the two previous video lines, produces nine taps per active pixel, and zero-pads taps outside the frame. It also delays the sync and enable signals so they stay aligned with the taps.

## Interface
- `H_ACTIVE`, default 1280: active pixels per line, which is also the line-buffer depth.
- `CNT_W`, default 12: width of the column and row counters; must satisfy 2^CNT_W > H_ACTIVE.
- `video_clk`, in, 1: pixel clock; the block's only clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `vs_in`, in, 1: vertical sync, active-high; a rising edge starts a new frame.
- `hs_in`, in, 1: horizontal sync, passed through delayed.
- `de_in`, in, 1: data enable; high during active pixels.
- `bin_in`, in, 1: binary pixel, valid when `de_in` = 1.
- `vs_out`, `hs_out`, `de_out`, out, 1 each: inputs delayed by 2 clocks.
- `bin_data_11`, `bin_data_12`, `bin_data_13`, out, 1 each: window row y-2, columns x-2, x-1, x.
- `bin_data_21`, `bin_data_22`, `bin_data_23`, out, 1 each: window row y-1, columns x-2, x-1, x.
- `bin_data_31`, `bin_data_32`, `bin_data_33`, out, 1 each: window row y (current row), columns x-2, x-1, x.

## Operation
- Column counter `x`:
  - Increments on each cycle with `de_in` = 1.
  - Clears on the cycle after `de_in` falls.
  - Saturates at H_ACTIVE-1.
- Row counter `y`:
  - Increments on each falling edge of `de_in`.
  - Clears on the rising edge of `vs_in`.
  - Saturates at 2^CNT_W-1.
- Two line buffers, LB_A (holds line y-1) and LB_B (holds line y-2). On each `de_in` = 1 cycle:
  - Both buffers are read at address `x`.
  - `LB_A[x]` is written with `bin_in`.
  - `LB_B[x]` is written with the old `LB_A[x]` (read-before-write).
- Writes are suppressed when the pixel count in a line exceeds H_ACTIVE. Taps for those extra pixels still output the current row, with rows y-1 and y-2 reading as 0.
- Vertical padding: if `y` = 0, rows y-1 and y-2 are forced to 0. If `y` = 1, row y-2 is forced to 0.
- Horizontal padding: the column shift registers clear when `de_in` is low. At `x` = 0, taps for columns x-1 and x-2 are 0; at `x` = 1, the tap for column x-2 is 0.
- When `de_out` = 0, all nine taps are 0.
- The window's bottom-right tap is the newest pixel. The window centre `bin_data_22` is pixel (x-1, y-1). Downstream stages accept this one-row, one-column spatial offset.
- Line-buffer contents are not cleared by reset. Row padding masks stale data until two lines have been written.

## Timing
- Latency is 2 clocks from `bin_in`/`de_in`/`hs_in`/`vs_in` to the taps and `*_out`:
  - Stage 1 registers `bin_in`, the line-buffer read data, and the delayed syncs.
  - Stage 2 registers the column shift registers, which drive the taps.
- Reset values: all outputs 0; counters 0; shift and sync-delay registers 0.
- Reset asserted mid-frame: outputs go to 0 immediately. After release, the block restarts with `y` = 0, so the first two rows are padded.
- A `vs_in` rising edge coinciding with `de_in` = 1 is a protocol error. In that case `y` clears and `x` keeps counting.
- Back-to-back lines with one blanking cycle must work: `x` clears during the single low cycle of `de_in`.
- Throughput is one pixel per clock with no stalls.

## Structure
- Shared package `bin_win_pkg` holds:
  - `BIN_WIN_LAT` = 2.
  - `PAD_VAL` = 1'b0.
  - Row-index constants for y-2, y-1 and y.
- Sub-module `bin_line_buf`: 1-bit wide, H_ACTIVE deep, synchronous read-before-write single-clock RAM. It is instantiated twice.
- Counters, padding masks, column shift registers and sync delay live in the top module.

## Test plan
- Frame 8×4 (H_ACTIVE = 8), all `bin_in` = 1: row 0 outputs 33/32/31 = 1/0/0 at x = 0, then 1/1/1 from x = 2. Rows 1x and 2x are 0. From row 2, x ≥ 2, all nine taps = 1.
- Single pixel = 1 at (3,1) in a zero frame: `bin_data_33` = 1 at (3,1), `bin_data_23` = 1 at (3,2), `bin_data_11` = 1 at (5,3). All other taps stay 0 throughout.
- Sync alignment: toggle `hs_in`/`vs_in`/`de_in` with random patterns; each `*_out` equals its input delayed by exactly 2 clocks.
- Reset pulse in row 2, column 4: all outputs are 0 during reset. The next frame's row 0 shows padded rows even though the RAMs hold stale data.
- Overlong line of 10 pixels with H_ACTIVE = 8: `x` saturates at 7 and the RAM is not written beyond address 7. The next line reads the correct data for columns 0–7.
- One-cycle horizontal blanking between lines: window contents match the reference model with no column carry-over across lines.

Source files
------------

// File: rtl/bin_win_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bin_win_pkg
// Brief    : Shared constants and types for the 3x3 binary window generator.
// Revision : 1.0 - initial release
// ============================================================================
package bin_win_pkg;

    // Clocks from pixel input to aligned taps and delayed syncs
    localparam int   BIN_WIN_LAT = 2;

    // Value substituted for taps that fall outside the frame
    localparam logic PAD_VAL     = 1'b0;

    // Window row indices: oldest line first, current line last
    localparam int   ROW_YM2     = 0;
    localparam int   ROW_YM1     = 1;
    localparam int   ROW_Y       = 2;

    // Video timing bundle carried through the sync delay line
    typedef struct packed {
        logic vs;
        logic hs;
        logic de;
    } sync_t;

endpackage
`default_nettype wire

// File: rtl/bin_line_buf.sv
`default_nettype none
// ============================================================================
// Module   : bin_line_buf
// Brief    : 1-bit line buffer RAM, registered read, read-before-write on a
//            shared address. Separate read/write addresses let the second
//            buffer in the cascade be written one clock after it is read.
// Revision : 1.0 - initial release
// ============================================================================
module bin_line_buf #(
    parameter int DEPTH = 1280,
    parameter int AW    = 11
) (
    input  logic          i_clk,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic          o_rd_data,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic          i_wr_data
);

    logic r_mem [0:DEPTH-1];

    // Registered read returns the old contents when the write hits the same address
    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bin_win3x3_gen.sv
`default_nettype none
// ============================================================================
// Module   : bin_win3x3_gen
// Brief    : 3x3 binary neighbourhood window from a raster 1-bit pixel stream,
//            zero-padded at frame edges, syncs delayed to stay aligned.
// Revision : 1.0 - initial release
// ============================================================================
module bin_win3x3_gen
    import bin_win_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int CNT_W    = 12
) (
    input  logic video_clk,
    input  logic rst_n,
    input  logic vs_in,
    input  logic hs_in,
    input  logic de_in,
    input  logic bin_in,
    output logic vs_out,
    output logic hs_out,
    output logic de_out,
    output logic bin_data_11,
    output logic bin_data_12,
    output logic bin_data_13,
    output logic bin_data_21,
    output logic bin_data_22,
    output logic bin_data_23,
    output logic bin_data_31,
    output logic bin_data_32,
    output logic bin_data_33
);

    localparam int               AW       = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [CNT_W-1:0] C_X_LAST = CNT_W'(H_ACTIVE - 1);

    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic             r_x_ovf;
    sync_t            r_sync [0:BIN_WIN_LAT-1];

    logic             r_bin1;
    logic             r_we1;
    logic [AW-1:0]    r_addr1;
    logic             r_pad_ym1;
    logic             r_pad_ym2;
    logic [0:2]       r_win [0:2];

    logic [AW-1:0]    w_addr;
    logic             w_lb_we;
    logic             w_lb_a_q;
    logic             w_lb_b_q;
    logic             w_vs_rise;
    logic             w_de_fall;
    logic [2:0]       w_col;

    assign w_addr    = r_x[AW-1:0];
    // Pixels past the end of an overlong line must not clobber the last column
    assign w_lb_we   = de_in & ~r_x_ovf;
    assign w_vs_rise = vs_in & ~r_sync[0].vs;
    assign w_de_fall = ~de_in & r_sync[0].de;

    // Sync delay line, one entry per pipeline stage
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BIN_WIN_LAT; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= '{vs: vs_in, hs: hs_in, de: de_in};
            for (int i = 1; i < BIN_WIN_LAT; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Column counter: saturates at the last column and flags any extra pixels
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_x_ovf <= 1'b0;
        end else if (de_in) begin
            if (r_x == C_X_LAST) begin
                r_x_ovf <= 1'b1;
            end else begin
                r_x <= r_x + CNT_W'(1);
            end
        end else begin
            r_x     <= '0;
            r_x_ovf <= 1'b0;
        end
    end

    // Row counter: cleared by frame start, advanced at each line end, saturating
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y <= '0;
        end else if (w_vs_rise) begin
            r_y <= '0;
        end else if (w_de_fall && (r_y != '1)) begin
            r_y <= r_y + CNT_W'(1);
        end
    end

    // LB_A holds line y-1; written with the live pixel
    bin_line_buf #(
        .DEPTH (H_ACTIVE),
        .AW    (AW)
    ) u_lb_a (
        .i_clk     (video_clk),
        .i_rd_en   (de_in),
        .i_rd_addr (w_addr),
        .o_rd_data (w_lb_a_q),
        .i_wr_en   (w_lb_we),
        .i_wr_addr (w_addr),
        .i_wr_data (bin_in)
    );

    // LB_B holds line y-2; receives the old LB_A word one clock after it was read
    bin_line_buf #(
        .DEPTH (H_ACTIVE),
        .AW    (AW)
    ) u_lb_b (
        .i_clk     (video_clk),
        .i_rd_en   (de_in),
        .i_rd_addr (w_addr),
        .o_rd_data (w_lb_b_q),
        .i_wr_en   (r_we1),
        .i_wr_addr (r_addr1),
        .i_wr_data (w_lb_a_q)
    );

    // Stage 1: live pixel, write bookkeeping for LB_B and row padding masks
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin1    <= 1'b0;
            r_we1     <= 1'b0;
            r_addr1   <= '0;
            r_pad_ym1 <= 1'b0;
            r_pad_ym2 <= 1'b0;
        end else begin
            r_bin1    <= bin_in;
            r_we1     <= w_lb_we;
            r_addr1   <= w_addr;
            r_pad_ym1 <= (r_y == '0);
            r_pad_ym2 <= (r_y < CNT_W'(2));
        end
    end

    // Newest column; buffered rows are padded above the frame and on overlong pixels
    assign w_col[ROW_Y]   = r_bin1;
    assign w_col[ROW_YM1] = (r_pad_ym1 | ~r_we1) ? PAD_VAL : w_lb_a_q;
    assign w_col[ROW_YM2] = (r_pad_ym2 | ~r_we1) ? PAD_VAL : w_lb_b_q;

    // Stage 2: column shift registers, flushed in blanking so lines never bleed
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r] <= '0;
            end
        end else if (!r_sync[0].de) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r] <= {3{PAD_VAL}};
            end
        end else begin
            for (int r = 0; r < 3; r++) begin
                r_win[r] <= {r_win[r][1], r_win[r][2], w_col[r]};
            end
        end
    end

    assign vs_out      = r_sync[BIN_WIN_LAT-1].vs;
    assign hs_out      = r_sync[BIN_WIN_LAT-1].hs;
    assign de_out      = r_sync[BIN_WIN_LAT-1].de;

    assign bin_data_11 = r_win[ROW_YM2][0];
    assign bin_data_12 = r_win[ROW_YM2][1];
    assign bin_data_13 = r_win[ROW_YM2][2];
    assign bin_data_21 = r_win[ROW_YM1][0];
    assign bin_data_22 = r_win[ROW_YM1][1];
    assign bin_data_23 = r_win[ROW_YM1][2];
    assign bin_data_31 = r_win[ROW_Y][0];
    assign bin_data_32 = r_win[ROW_Y][1];
    assign bin_data_33 = r_win[ROW_Y][2];

endmodule
`default_nettype wire

// File: tb/tb_bin_win3x3_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_win3x3_gen
// Brief    : Scoreboard bench for bin_win3x3_gen with an 8-pixel line.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_win3x3_gen;
    import bin_win_pkg::*;

    localparam int H    = 8;
    localparam int CW   = 4;
    localparam int YMAX = (1 << CW) - 1;

    typedef struct {
        logic [11:0] v;
        int          c;
        int          y;
    } sb_t;

    logic video_clk = 1'b0;
    logic rst_n;
    logic vs_in, hs_in, de_in, bin_in;
    logic vs_out, hs_out, de_out;
    logic bin_data_11, bin_data_12, bin_data_13;
    logic bin_data_21, bin_data_22, bin_data_23;
    logic bin_data_31, bin_data_32, bin_data_33;

    sb_t  sb_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic line_a [0:H-1];
    logic line_b [0:H-1];
    logic snap_a [0:H-1];
    logic snap_b [0:H-1];
    logic cur    [0:63];
    int   m_c;
    int   m_y;
    logic m_prev_de;
    logic m_prev_vs;

    bin_win3x3_gen #(
        .H_ACTIVE (H),
        .CNT_W    (CW)
    ) dut (
        .video_clk   (video_clk),
        .rst_n       (rst_n),
        .vs_in       (vs_in),
        .hs_in       (hs_in),
        .de_in       (de_in),
        .bin_in      (bin_in),
        .vs_out      (vs_out),
        .hs_out      (hs_out),
        .de_out      (de_out),
        .bin_data_11 (bin_data_11),
        .bin_data_12 (bin_data_12),
        .bin_data_13 (bin_data_13),
        .bin_data_21 (bin_data_21),
        .bin_data_22 (bin_data_22),
        .bin_data_23 (bin_data_23),
        .bin_data_31 (bin_data_31),
        .bin_data_32 (bin_data_32),
        .bin_data_33 (bin_data_33)
    );

    always #5 video_clk = ~video_clk;

    function automatic logic [11:0] dut_vec();
        return {vs_out, hs_out, de_out,
                bin_data_11, bin_data_12, bin_data_13,
                bin_data_21, bin_data_22, bin_data_23,
                bin_data_31, bin_data_32, bin_data_33};
    endfunction

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {vs,hs,de,taps}=%03h expected %03h", tag, got, exp);
        end
    endtask

    // One pixel clock: compare the entry now due, drive new inputs, push their expectation
    task automatic drive(input logic vs, input logic hs, input logic de, input logic bin);
        sb_t  e;
        sb_t  o;
        int   j;
        logic t;
        @(negedge video_clk);
        if (sb_q.size() >= BIN_WIN_LAT) begin
            o = sb_q.pop_front();
            chk($sformatf("win x%0d y%0d", o.c, o.y), dut_vec(), o.v);
        end
        vs_in  = vs;
        hs_in  = hs;
        de_in  = de;
        bin_in = bin;
        e.v = '0;
        e.v[11:9] = {vs, hs, de};
        e.c = m_c;
        e.y = m_y;
        if (de) begin
            if (!m_prev_de) begin
                snap_a = line_a;
                snap_b = line_b;
            end
            cur[m_c] = bin;
            for (int r = 0; r < 3; r++) begin
                for (int k = 0; k < 3; k++) begin
                    j = m_c - 2 + k;
                    t = 1'b0;
                    if (j >= 0) begin
                        if (r == 2) begin
                            t = cur[j];
                        end else if (j < H) begin
                            if (r == 1 && m_y >= 1) t = snap_a[j];
                            if (r == 0 && m_y >= 2) t = snap_b[j];
                        end
                    end
                    e.v[8 - (r * 3 + k)] = t;
                end
            end
            if (m_c < H) begin
                line_b[m_c] = line_a[m_c];
                line_a[m_c] = bin;
            end
            if (m_c < 63) m_c++;
        end else begin
            m_c = 0;
        end
        if (vs && !m_prev_vs) begin
            m_y = 0;
        end else if (!de && m_prev_de && m_y < YMAX) begin
            m_y++;
        end
        m_prev_de = de;
        m_prev_vs = vs;
        sb_q.push_back(e);
    endtask

    task automatic send_line(input int len, input logic [15:0] bits, input int blank);
        for (int i = 0; i < len; i++) begin
            drive(1'b0, 1'b0, 1'b1, bits[i]);
        end
        for (int i = 0; i < blank; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic vsync();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge video_clk);
        rst_n  = 1'b0;
        vs_in  = 1'b0;
        hs_in  = 1'b0;
        de_in  = 1'b0;
        bin_in = 1'b0;
        #1;
        chk("reset_async", dut_vec(), 12'h000);
        for (int i = 0; i < cycles; i++) begin
            @(negedge video_clk);
            chk("reset_hold", dut_vec(), 12'h000);
        end
        sb_q.delete();
        m_c       = 0;
        m_y       = 0;
        m_prev_de = 1'b0;
        m_prev_vs = 1'b0;
        rst_n     = 1'b1;
    endtask

    initial begin
        logic vs_r;
        logic de_r;
        rst_n  = 1'b0;
        vs_in  = 1'b0;
        hs_in  = 1'b0;
        de_in  = 1'b0;
        bin_in = 1'b0;
        for (int i = 0; i < H; i++) begin
            line_a[i] = 1'b0;
            line_b[i] = 1'b0;
            snap_a[i] = 1'b0;
            snap_b[i] = 1'b0;
        end
        for (int i = 0; i < 64; i++) cur[i] = 1'b0;

        do_reset(3);

        // All-ones frame
        vsync();
        for (int r = 0; r < 4; r++) send_line(H, 16'hFFFF, 3);

        // Single set pixel at (3,1)
        vsync();
        for (int r = 0; r < 4; r++) send_line(H, (r == 1) ? 16'h0008 : 16'h0000, 3);

        // Overlong first line: pixel 7 is 0, extra pixels 8 and 9 are 1
        vsync();
        send_line(10, 16'b0000_0011_0110_1001, 3);
        for (int r = 1; r < 4; r++) send_line(H, 16'($urandom), 3);

        // Back-to-back lines with a single blanking cycle
        vsync();
        for (int r = 0; r < 4; r++) send_line(H, 16'($urandom), 1);

        // Reset in row 2 at column 4, then a fresh frame over stale buffers
        vsync();
        send_line(H, 16'($urandom), 2);
        send_line(H, 16'($urandom), 2);
        send_line(4, 16'($urandom), 0);
        do_reset(3);
        vsync();
        for (int r = 0; r < 4; r++) send_line(H, 16'($urandom), 2);

        // Random sync/enable activity; vs never rises together with de
        vs_r = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 19) == 0) vs_r = ~vs_r;
            de_r = ($urandom_range(0, 9) < 7);
            if (vs_r && !m_prev_vs) de_r = 1'b0;
            drive(vs_r, 1'($urandom), de_r, 1'($urandom));
        end

        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
